hit_event_queue: RTL and testbench



---
 rtl/hit_pkg.sv | 39 +++
 rtl/hit_fifo.sv | 55 +++++
 rtl/hit_event_queue.sv | 144 ++++++++++++++
 tb/tb_hit_event_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_pkg.sv
// Shared types for the hit event queue: detector bin classes, the queued
// event record and the onset/holdoff state encoding.
package hit_pkg;

    // Default timestamp width; the top-level TS_WIDTH parameter mirrors it.
    localparam int TS_WIDTH = 24;

    typedef enum logic [2:0] {
        SILENCE = 3'd0,
        BIN1    = 3'd1,
        BIN2    = 3'd2,
        BIN3    = 3'd3,
        BIN4    = 3'd4
    } bin_t;

    typedef struct packed {
        bin_t                bin;
        logic [TS_WIDTH-1:0] ts;
    } hit_event_t;

    typedef enum logic {
        LISTEN = 1'b0,
        HOLD   = 1'b1
    } state_t;

    // Detector classes 5-7 carry no note and are folded into silence.
    function automatic bin_t map_class(input logic [2:0] cls);
        bin_t res;
        case (cls)
            3'd1:    res = BIN1;
            3'd2:    res = BIN2;
            3'd3:    res = BIN3;
            3'd4:    res = BIN4;
            default: res = SILENCE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// Generic synchronous show-ahead FIFO. Pointers carry one extra MSB so that
// count = wr_ptr - rd_ptr distinguishes full from empty. A write into a full
// FIFO is accepted only when a pop happens in the same cycle.
module hit_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 27,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             rd_ok;
    logic             wr_ok;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update: advance on accepted writes and pops.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage: write the tail slot on an accepted write.
    // NOTE: the array is reset because the show-ahead head must read 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/hit_event_queue.sv
// Onset detector with refractory holdoff that timestamps note onsets from the
// tone detector and queues {bin, timestamp} events for software to drain.
// Optional interrupt output enabled by defining HIT_EVENT_IRQ_EN.
module hit_event_queue
    import hit_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int TS_WIDTH   = hit_pkg::TS_WIDTH,
    parameter  int HOLDOFF    = 32,
    parameter  int HOLD_WIDTH = 6,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flag,
    input  logic [2:0]            overall_result,
    input  logic                  rd_en,
    input  logic                  clear_overflow,
`ifdef HIT_EVENT_IRQ_EN
    input  logic                  irq_mask,
    input  logic                  irq_clear,
    output logic                  irq,
`endif
    output logic [3+TS_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  holdoff_active
);

    typedef struct packed {
        bin_t                bin;
        logic [TS_WIDTH-1:0] ts;
    } event_t;

    state_t                state_q, state_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic [TS_WIDTH-1:0]   ts_q;
    bin_t                  prev_q;
    logic                  overflow_q;
    bin_t                  cur_bin;
    logic                  onset;
    logic                  push;
    logic                  full;
    logic                  drop;
    event_t                wr_ev;

    assign cur_bin  = map_class(overall_result);
    assign onset    = flag & (cur_bin != SILENCE) & (cur_bin != prev_q);
    // A full FIFO still takes the event when the head is popped in the same cycle.
    assign drop     = push & full & ~rd_en;
    assign wr_ev    = '{bin: cur_bin, ts: ts_q};
    assign overflow = overflow_q;

    // Timestamp and previous-bin tracking, advanced once per detector frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q   <= '0;
            prev_q <= SILENCE;
        end else if (flag) begin
            ts_q   <= ts_q + TS_WIDTH'(1);
            prev_q <= cur_bin;
        end
    end

    // Holdoff FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LISTEN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Holdoff FSM next state: accept an onset in LISTEN, then ignore HOLDOFF frames.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        push           = 1'b0;
        holdoff_active = 1'b0;
        case (state_q)
            LISTEN: begin
                if (onset) begin
                    push    = 1'b1;
                    hold_d  = HOLD_WIDTH'(HOLDOFF - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                holdoff_active = 1'b1;
                if (flag) begin
                    if (hold_q == '0) state_d = LISTEN;
                    else              hold_d  = hold_q - HOLD_WIDTH'(1);
                end
            end
            default: state_d = LISTEN;
        endcase
    end

    // Overflow sticky: a lost event outranks a software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               overflow_q <= 1'b0;
        else if (drop)           overflow_q <= 1'b1;
        else if (clear_overflow) overflow_q <= 1'b0;
    end

`ifdef HIT_EVENT_IRQ_EN
    logic pend_q;
    logic irq_q;

    // Interrupt pending sticky and masked, registered interrupt output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (push & ~drop)   pend_q <= 1'b1;
            else if (irq_clear) pend_q <= 1'b0;
            irq_q <= pend_q & ~irq_mask;
        end
    end

    assign irq = irq_q;
`endif

    hit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3 + TS_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (wr_ev),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_hit_event_queue.sv
// Bench for hit_event_queue. Three instances share one stimulus stream:
//   a: DEPTH 16, TS_WIDTH 24, HOLDOFF 4
//   b: DEPTH 4,  TS_WIDTH 24, HOLDOFF 1
//   c: DEPTH 16, TS_WIDTH 4,  HOLDOFF 1
// An event-list model predicts every instance; directed literals pin the model.
module tb_hit_event_queue;

    logic       clk;
    logic       reset;
    logic       flag;
    logic [2:0] cls;
    logic       rd_en;
    logic       clr;

    logic [26:0] rd_data_a, rd_data_b;
    logic [6:0]  rd_data_c;
    logic [4:0]  count_a, count_c;
    logic [2:0]  count_b;
    logic        empty_a, empty_b, empty_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        hold_a, hold_b, hold_c;

    int checks = 0;
    int errors = 0;

    hit_event_queue #(.DEPTH(16), .TS_WIDTH(24), .HOLDOFF(4), .HOLD_WIDTH(6)) dut_a (
        .clk(clk), .reset(reset), .flag(flag), .overall_result(cls), .rd_en(rd_en),
        .clear_overflow(clr), .rd_data(rd_data_a), .empty(empty_a), .count(count_a),
        .overflow(ovf_a), .holdoff_active(hold_a));

    hit_event_queue #(.DEPTH(4), .TS_WIDTH(24), .HOLDOFF(1), .HOLD_WIDTH(6)) dut_b (
        .clk(clk), .reset(reset), .flag(flag), .overall_result(cls), .rd_en(rd_en),
        .clear_overflow(clr), .rd_data(rd_data_b), .empty(empty_b), .count(count_b),
        .overflow(ovf_b), .holdoff_active(hold_b));

    hit_event_queue #(.DEPTH(16), .TS_WIDTH(4), .HOLDOFF(1), .HOLD_WIDTH(6)) dut_c (
        .clk(clk), .reset(reset), .flag(flag), .overall_result(cls), .rd_en(rd_en),
        .clear_overflow(clr), .rd_data(rd_data_c), .empty(empty_c), .count(count_c),
        .overflow(ovf_c), .holdoff_active(hold_c));

    // Uniform views of the three instances for the compare loop.
    logic [26:0] v_rd  [3];
    logic [4:0]  v_cnt [3];
    logic        v_emp [3];
    logic        v_ovf [3];
    logic        v_hld [3];
    assign v_rd[0]  = rd_data_a;
    assign v_rd[1]  = rd_data_b;
    assign v_rd[2]  = {20'b0, rd_data_c};
    assign v_cnt[0] = count_a;
    assign v_cnt[1] = {2'b0, count_b};
    assign v_cnt[2] = count_c;
    assign v_emp[0] = empty_a;
    assign v_emp[1] = empty_b;
    assign v_emp[2] = empty_c;
    assign v_ovf[0] = ovf_a;
    assign v_ovf[1] = ovf_b;
    assign v_ovf[2] = ovf_c;
    assign v_hld[0] = hold_a;
    assign v_hld[1] = hold_b;
    assign v_hld[2] = hold_c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: frame counter, last bin, frames of holdoff left, the list of
    // queued events (head at index 0) and the overflow sticky.
    int P_DEPTH [3] = '{16, 4, 16};
    int P_HOLD  [3] = '{4, 1, 1};
    int P_TSW   [3] = '{24, 24, 4};

    int          m_ts   [3];
    int          m_prev [3];
    int          m_hold [3];
    int          m_cnt  [3];
    bit          m_ovf  [3];
    logic [26:0] m_list [3][16];

    int          mdl_cb;
    bit          mdl_pop;
    bit          mdl_drop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_ts[k] = 0; m_prev[k] = 0; m_hold[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            end
        end else begin
            mdl_cb = (cls >= 3'd1 && cls <= 3'd4) ? int'(cls) : 0;
            for (int k = 0; k < 3; k++) begin
                mdl_drop = 0;
                mdl_pop  = rd_en && (m_cnt[k] > 0);
                if (mdl_pop) begin
                    for (int j = 0; j < 15; j++) m_list[k][j] = m_list[k][j+1];
                    m_cnt[k]--;
                end
                if (flag) begin
                    if (m_hold[k] > 0) begin
                        m_hold[k]--;
                    end else if (mdl_cb != 0 && mdl_cb != m_prev[k]) begin
                        if (m_cnt[k] < P_DEPTH[k]) begin
                            m_list[k][m_cnt[k]] = (27'(mdl_cb) << P_TSW[k]) | 27'(m_ts[k]);
                            m_cnt[k]++;
                        end else begin
                            mdl_drop = 1;
                        end
                        m_hold[k] = P_HOLD[k];
                    end
                    m_prev[k] = mdl_cb;
                    m_ts[k]   = (m_ts[k] + 1) % (1 << P_TSW[k]);
                end
                if (mdl_drop) m_ovf[k] = 1;
                else if (clr) m_ovf[k] = 0;
            end
        end
    end

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("count[%0d]", k), 32'(v_cnt[k]), 32'(m_cnt[k]));
            check($sformatf("empty[%0d]", k), 32'(v_emp[k]), 32'(m_cnt[k] == 0));
            check($sformatf("overflow[%0d]", k), 32'(v_ovf[k]), 32'(m_ovf[k]));
            check($sformatf("holdoff[%0d]", k), 32'(v_hld[k]), 32'(m_hold[k] > 0));
            if (m_cnt[k] > 0)
                check($sformatf("rd_data[%0d]", k), 32'(v_rd[k]), 32'(m_list[k][0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit f, input logic [2:0] c, input bit r, input bit cl);
        flag = f; cls = c; rd_en = r; clr = cl;
        @(posedge clk);
        #1;
        flag = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flag = 1'b0; cls = 3'd0; rd_en = 1'b0; clr = 1'b0;
        #3;
        check("reset_rd_data", 32'(rd_data_a), 32'h0);
        check("reset_empty", 32'(empty_a), 32'd1);
        check("reset_count", 32'(count_a), 32'd0);
        check("reset_holdoff", 32'(hold_a), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single onset: 3 silent frames then class 2 for 10 frames.
        for (int i = 0; i < 13; i++) begin
            step(1'b1, (i < 3) ? 3'd0 : 3'd2, 1'b0, 1'b0);
            check($sformatf("single_holdoff_f%0d", i), 32'(hold_a), 32'((i >= 3) && (i <= 6)));
        end
        check("single_count", 32'(count_a), 32'd1);
        check("single_rd_data", 32'(rd_data_a), 32'h2000003);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("single_empty_after_pop", 32'(empty_a), 32'd1);

        // Holdoff suppression.
        pulse_reset();
        foreach (P_HOLD[i]) begin end
        step(1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        check("supp_count", 32'(count_a), 32'd2);
        check("supp_head0", 32'(rd_data_a), 32'h1000000);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("supp_head1", 32'(rd_data_a), 32'h3000006);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("supp_empty", 32'(empty_a), 32'd1);

        // Overflow on the 4-deep instance with alternating classes.
        pulse_reset();
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? 3'd1 : 3'd0, 1'b0, 1'b0);
        check("ovf_count", 32'(count_b), 32'd4);
        check("ovf_flag", 32'(ovf_b), 32'd1);
        check("ovf_head", 32'(rd_data_b), 32'h1000000);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(ovf_b), 32'd0);

        // Full with simultaneous pop: onset at ts 10 while popping.
        step(1'b1, 3'd2, 1'b1, 1'b0);
        check("fullpop_count", 32'(count_b), 32'd4);
        check("fullpop_ovf", 32'(ovf_b), 32'd0);
        check("fullpop_head", 32'(rd_data_b), 32'h1000002);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b1, 1'b0);
        check("fullpop_tail", 32'(rd_data_b), 32'h200000A);

        // Timestamp wrap on the 4-bit instance.
        pulse_reset();
        for (int i = 0; i < 15; i++) step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b0);
        check("wrap_count", 32'(count_c), 32'd2);
        check("wrap_head0", 32'(rd_data_c), 32'h1F);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("wrap_head1", 32'(rd_data_c), 32'h21);
        step(1'b0, 3'd0, 1'b1, 1'b0);

        // Queue two more events on instance c and stay in HOLD.
        step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd4, 1'b0, 1'b0);
        check("pre_reset_count", 32'(count_c), 32'd2);
        check("pre_reset_holdoff", 32'(hold_c), 32'd1);

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        check("areset_empty", 32'(empty_c), 32'd1);
        check("areset_count", 32'(count_c), 32'd0);
        check("areset_holdoff", 32'(hold_c), 32'd0);
        check("areset_overflow", 32'(ovf_b), 32'd0);
        check("areset_rd_data", 32'(rd_data_c), 32'd0);
        #3 reset = 1'b0;

        // First onset after release, with a pop request on the empty FIFO.
        step(1'b1, 3'd1, 1'b1, 1'b0);
        check("post_count", 32'(count_a), 32'd1);
        check("post_rd_data_a", 32'(rd_data_a), 32'h1000000);
        check("post_rd_data_c", 32'(rd_data_c), 32'h10);

        repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
